// File: rtl/pixel_write_packer_pkg.sv
// Shared definitions for the pixel write path: VRAM pixel field layout,
// the ordered-dither matrix, burst payload type and the flush FSM states.
package pixel_write_packer_pkg;

    localparam int unsigned LANES   = 8;
    localparam int unsigned PIX_W   = 16;
    localparam int unsigned BURST_W = LANES * PIX_W;
    localparam int unsigned CH_W    = 5;

    // 16-bit VRAM pixel: R[4:0], G[9:5], B[14:10], M[15]
    localparam int unsigned R_LSB = 0;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_LSB = 10;
    localparam int unsigned M_BIT = 15;

    // 4x4 ordered dither offsets, indexed [y[1:0]][x[1:0]]
    localparam logic signed [2:0] DITHER_MATRIX [4][4] = '{
        '{3'sb100, 3'sb000, 3'sb101, 3'sb001},   // -4  0 -3  1
        '{3'sb010, 3'sb110, 3'sb011, 3'sb111},   //  2 -2  3 -1
        '{3'sb101, 3'sb001, 3'sb100, 3'sb000},   // -3  1 -4  0
        '{3'sb011, 3'sb111, 3'sb010, 3'sb110}    //  3 -1  2 -2
    };

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_MOVE  = 2'd1,
        FLUSH_DRAIN = 2'd2
    } flush_state_t;

    typedef struct packed {
        logic [BURST_W-1:0] data;
        logic [LANES-1:0]   pixmask;
    } burst_t;

    // Add dither offset to an 8-bit channel, clamp to 0..255, keep top 5 bits.
    function automatic logic [CH_W-1:0] dither_clamp(input logic [7:0] c,
                                                     input logic signed [2:0] d);
        logic signed [9:0] s;
        s = signed'({2'b00, c}) + signed'({{7{d[2]}}, d});
        if (s[9])
            return '0;
        else if (s[8])
            return '1;
        else
            return CH_W'(unsigned'(s) >> 3);
    endfunction

endpackage

// File: rtl/pixel_dither_conv.sv
// Combinational 8:8:8 colour -> 16-bit VRAM pixel with optional ordered dither.
// Ports: r/g/b 8-bit channels, x_lo/y_lo low coordinate bits selecting the
// dither cell, dither_en, mask_bit (bit 15), word_c converted pixel.
module pixel_dither_conv
    import pixel_write_packer_pkg::*;
(
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    input  logic [1:0]       x_lo,
    input  logic [1:0]       y_lo,
    input  logic             dither_en,
    input  logic             mask_bit,
    output logic [PIX_W-1:0] word_c
);

    logic signed [2:0] d;

    always_comb begin
        d      = dither_en ? DITHER_MATRIX[y_lo][x_lo] : 3'sb000;
        word_c = '0;
        word_c[R_LSB +: CH_W] = dither_clamp(r, d);
        word_c[G_LSB +: CH_W] = dither_clamp(g, d);
        word_c[B_LSB +: CH_W] = dither_clamp(b, d);
        word_c[M_BIT]         = mask_bit;
    end

endmodule

// File: rtl/pixel_write_packer.sv
// Converts blended pixels to 5:5:5+M, coalesces an 8-pixel-aligned row
// segment into a 128-bit masked burst and hands it to the VRAM write arbiter
// through a one-deep output register (accumulator + output = double buffer).
// Ports: pixel input (i_px_*, o_px_ready), dither/mask controls, flush
// request/done, burst output (o_wr_*, i_wr_ready).
module pixel_write_packer
    import pixel_write_packer_pkg::*;
#(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 9
)(
    input  logic               clk,
    input  logic               i_nrst,
    input  logic               i_px_valid,
    output logic               o_px_ready,
    input  logic [7:0]         i_px_r,
    input  logic [7:0]         i_px_g,
    input  logic [7:0]         i_px_b,
    input  logic [XW-1:0]      i_px_x,
    input  logic [YW-1:0]      i_px_y,
    input  logic               i_px_stp,
    input  logic               i_dither_en,
    input  logic               i_force_mask,
    input  logic               i_flush,
    output logic               o_flush_done,
    output logic               o_wr_valid,
    input  logic               i_wr_ready,
    output logic [XW-4:0]      o_wr_seg_x,
    output logic [YW-1:0]      o_wr_seg_y,
    output logic [BURST_W-1:0] o_wr_data,
    output logic [LANES-1:0]   o_wr_pixmask
);

    localparam int unsigned SXW = XW - 3;

    logic [PIX_W-1:0] px_word;
    logic [2:0]       px_lane;
    logic             px_fire;
    logic             wr_fire;
    logic             key_match;
    logic             acc_nonempty;
    logic             acc_close;
    logic             out_load;
    logic             flush_pending;
    logic             flush_move;

    logic [SXW-1:0]   acc_seg_x;
    logic [YW-1:0]    acc_seg_y;
    burst_t           acc_q;
    burst_t           acc_d;

    logic             out_full;
    logic [SXW-1:0]   out_seg_x;
    logic [YW-1:0]    out_seg_y;
    burst_t           out_q;

    flush_state_t     state_q;
    flush_state_t     state_d;

    pixel_dither_conv u_conv (
        .r         (i_px_r),
        .g         (i_px_g),
        .b         (i_px_b),
        .x_lo      (i_px_x[1:0]),
        .y_lo      (i_px_y[1:0]),
        .dither_en (i_dither_en),
        .mask_bit  (i_force_mask | i_px_stp),
        .word_c    (px_word)
    );

    // Handshake and segment-change detection
    assign px_lane      = i_px_x[2:0];
    assign acc_nonempty = |acc_q.pixmask;
    assign key_match    = (acc_seg_y == i_px_y) && (acc_seg_x == i_px_x[XW-1:3]);
    assign o_px_ready   = !(acc_nonempty && out_full && !i_wr_ready) && !flush_pending;
    assign px_fire      = i_px_valid && o_px_ready;
    assign wr_fire      = out_full && i_wr_ready;
    assign acc_close    = px_fire && acc_nonempty && !key_match;
    assign out_load     = acc_close || flush_move;

    // Flush FSM: state register
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst)
            state_q <= FLUSH_IDLE;
        else
            state_q <= state_d;
    end

    // Flush FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            FLUSH_IDLE:  if (i_flush) state_d = FLUSH_MOVE;
            FLUSH_MOVE:  if (!acc_nonempty || !out_full || i_wr_ready) state_d = FLUSH_DRAIN;
            FLUSH_DRAIN: if (!out_full) state_d = FLUSH_IDLE;
            default:     state_d = FLUSH_IDLE;
        endcase
    end

    // Flush FSM: outputs; done fires in the first DRAIN cycle with the output slot empty
    always_comb begin
        flush_pending = (state_q != FLUSH_IDLE);
        flush_move    = (state_q == FLUSH_MOVE) && acc_nonempty && (!out_full || i_wr_ready);
        o_flush_done  = (state_q == FLUSH_DRAIN) && !out_full;
    end

    // Accumulator next value; a closing pixel starts from a clean segment
    always_comb begin
        acc_d = acc_q;
        if (flush_move) begin
            acc_d = '0;
        end else if (px_fire) begin
            if (acc_close)
                acc_d = '0;
            acc_d.data[PIX_W*px_lane +: PIX_W] = px_word;
            acc_d.pixmask[px_lane]             = 1'b1;
        end
    end

    // Accumulator registers
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            acc_q     <= '0;
            acc_seg_x <= '0;
            acc_seg_y <= '0;
        end else begin
            acc_q <= acc_d;
            if (px_fire) begin
                acc_seg_x <= i_px_x[XW-1:3];
                acc_seg_y <= i_px_y;
            end
        end
    end

    // Output register; a load wins over a same-cycle acceptance
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            out_full  <= 1'b0;
            out_q     <= '0;
            out_seg_x <= '0;
            out_seg_y <= '0;
        end else if (out_load) begin
            out_full  <= 1'b1;
            out_q     <= acc_q;
            out_seg_x <= acc_seg_x;
            out_seg_y <= acc_seg_y;
        end else if (wr_fire) begin
            out_full  <= 1'b0;
        end
    end

    assign o_wr_valid   = out_full;
    assign o_wr_seg_x   = out_seg_x;
    assign o_wr_seg_y   = out_seg_y;
    assign o_wr_data    = out_q.data;
    assign o_wr_pixmask = out_q.pixmask;

endmodule
